// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point command dispatcher.
package fp_pkg;

    typedef logic [31:0] fp_word_t;
    typedef logic [2:0]  fp_op_t;

    typedef struct packed {
        fp_word_t op1;
        fp_word_t op2;
        fp_op_t   op_sel;
    } fp_cmd_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StHold
    } disp_state_e;

    localparam int unsigned DefaultTimeout = 255;

endpackage

// File: rtl/fp_cmd_fifo.sv
// Synchronous FIFO of FPU commands; push is ignored when full, pop when empty.
module fp_cmd_fifo
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  fp_cmd_t                wdata,
    output fp_cmd_t                rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fp_cmd_t             mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     count_q;
    logic                do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fp_op_dispatcher.sv
// Queues host FPU commands and issues them one at a time, returning each result
// (or a timeout marker) through a valid/ready port.
module fp_op_dispatcher
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_op1,
    input  logic [31:0]            in_op2,
    input  logic [2:0]             in_op_sel,
    output logic [31:0]            fpu_op1,
    output logic [31:0]            fpu_op2,
    output logic [2:0]             fpu_op_sel,
    output logic                   fpu_strobe,
    input  logic                   fpu_done,
    input  logic [31:0]            fpu_result,
    input  logic                   fpu_overflow,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [31:0]            res_data,
    output logic                   res_overflow,
    output logic                   res_timeout,
    output logic [2:0]             res_op_sel,
    output logic [$clog2(DEPTH):0] count
);

    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

    disp_state_e state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d, wait_inc;
    fp_word_t    fpu_op1_q, fpu_op1_d, fpu_op2_q, fpu_op2_d;
    fp_op_t      fpu_op_sel_q, fpu_op_sel_d;
    fp_word_t    res_data_q, res_data_d;
    logic        res_overflow_q, res_overflow_d;
    logic        res_timeout_q, res_timeout_d;
    fp_op_t      res_op_sel_q, res_op_sel_d;

    fp_cmd_t     in_cmd, head_cmd;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty, load;

    assign in_cmd    = '{op1: in_op1, op2: in_op2, op_sel: in_op_sel};
    assign in_ready  = !rst && !fifo_full;
    assign fifo_push = in_valid && in_ready;

    fp_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_cmd),
        .rdata (head_cmd),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign wait_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

    // Operands are latched and the head popped on the edge entering StIssue,
    // so they are valid for the whole strobe cycle.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        fpu_op1_d      = fpu_op1_q;
        fpu_op2_d      = fpu_op2_q;
        fpu_op_sel_d   = fpu_op_sel_q;
        res_data_d     = res_data_q;
        res_overflow_d = res_overflow_q;
        res_timeout_d  = res_timeout_q;
        res_op_sel_d   = res_op_sel_q;
        load           = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StIssue;
                    load    = 1'b1;
                end
            end
            StIssue: begin
                state_d    = StWait;
                wait_cnt_d = '0;
            end
            StWait: begin
                wait_cnt_d = wait_inc;
                if (fpu_done) begin
                    state_d        = StHold;
                    res_data_d     = fpu_result;
                    res_overflow_d = fpu_overflow;
                    res_timeout_d  = 1'b0;
                    res_op_sel_d   = fpu_op_sel_q;
                end else if (wait_inc >= TimeoutVal) begin
                    state_d        = StHold;
                    res_data_d     = '0;
                    res_overflow_d = 1'b0;
                    res_timeout_d  = 1'b1;
                    res_op_sel_d   = fpu_op_sel_q;
                end
            end
            StHold: begin
                if (res_ready) begin
                    if (!fifo_empty) begin
                        state_d = StIssue;
                        load    = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            fpu_op1_d    = head_cmd.op1;
            fpu_op2_d    = head_cmd.op2;
            fpu_op_sel_d = head_cmd.op_sel;
        end
    end

    assign fifo_pop = load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            wait_cnt_q     <= '0;
            fpu_op1_q      <= '0;
            fpu_op2_q      <= '0;
            fpu_op_sel_q   <= '0;
            res_data_q     <= '0;
            res_overflow_q <= 1'b0;
            res_timeout_q  <= 1'b0;
            res_op_sel_q   <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            fpu_op1_q      <= fpu_op1_d;
            fpu_op2_q      <= fpu_op2_d;
            fpu_op_sel_q   <= fpu_op_sel_d;
            res_data_q     <= res_data_d;
            res_overflow_q <= res_overflow_d;
            res_timeout_q  <= res_timeout_d;
            res_op_sel_q   <= res_op_sel_d;
        end
    end

    assign fpu_op1      = fpu_op1_q;
    assign fpu_op2      = fpu_op2_q;
    assign fpu_op_sel   = fpu_op_sel_q;
    assign fpu_strobe   = (state_q == StIssue);
    assign res_valid    = (state_q == StHold);
    assign res_data     = res_data_q;
    assign res_overflow = res_overflow_q;
    assign res_timeout  = res_timeout_q;
    assign res_op_sel   = res_op_sel_q;

endmodule
